// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the MCU command sequencer: register map addresses,
// control register bit positions and the sequencer state encoding.
// ---------------------------------------------------------------------------
package bp_pkg;

  // MCU register map
  localparam int unsigned ADDR_CMD    = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned ADDR_CTRL   = 2;

  // Control register bit positions
  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_CLEAR_BIT = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE
  } seqState_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through output.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   i_push / i_din    : write request and data (ignored when full, unless a
//                       pop happens in the same cycle)
//   i_pop             : remove the head entry (ignored when empty)
//   i_flush           : empty the FIFO in one cycle
//   o_dout            : current head entry
//   o_full / o_empty  : occupancy flags
//   o_count           : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push into a full FIFO is still accepted when a pop frees a slot in the
  // same cycle, so simultaneous push/pop always leaves the count unchanged.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two; flush simply
  // rewinds everything back to the empty state.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_din;
  end

endmodule

// File: rtl/mc_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// mc_cmd_sequencer
// Bridges an asynchronous MCU register bus to a protocol engine. The MCU
// queues {opcode, operand} commands; the sequencer issues them one at a time
// and captures results of opcodes with bit7 set into a result FIFO.
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   mc_we, mc_oe          : MCU write / read strobes (active low, async)
//   mc_add, mc_din        : MCU address and write data
//   mc_dout, mc_dout_en   : registered read data and its drive enable
//   eng_start/cmd/data    : command strobe, opcode and operand to engine
//   eng_done, eng_rdata   : completion pulse and result from engine
//   irq0                  : result FIFO not empty
//   irq1                  : any error flag set
// ---------------------------------------------------------------------------
module mc_cmd_sequencer #(
  parameter int MC_ADD_WIDTH  = 6,
  parameter int MC_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_we,
  input  logic                     mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_din,
  output logic [MC_DATA_WIDTH-1:0] mc_dout,
  output logic                     mc_dout_en,
  output logic                     eng_start,
  output logic [7:0]               eng_cmd,
  output logic [7:0]               eng_data,
  input  logic                     eng_done,
  input  logic [7:0]               eng_rdata,
  output logic                     irq0,
  output logic                     irq1
);
  import bp_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  seqState_t r_state, w_nextState;

  logic [1:0]  r_weSync, r_oeSync;
  logic        r_wePrev, r_oePrev;
  logic        w_weFall, w_oeFall, w_oeRise;
  logic        w_addrCmd, w_addrStatus, w_addrCtrl;
  logic        w_cmdWrite, w_ctrlWrite, w_flush, w_clear;
  logic        r_run, r_overflow, r_underflow, r_timeout;
  logic        r_popPending, r_discard;
  logic [MC_DATA_WIDTH-1:0] r_dout;
  logic [7:0]  r_engCmd, r_engData, r_engRdata;
  logic [TW-1:0] r_waitCnt;
  logic        w_cmdPop, w_resPush, w_resPop, w_setTimeout, w_busy;
  logic [15:0] w_cmdHead, w_resHead, w_status;
  logic        w_cmdFull, w_cmdEmpty, w_resFull, w_resEmpty;
  logic [CW-1:0] w_cmdCount, w_resCount;

  // Strobe events are edges of the second synchronizer stage.
  assign w_weFall = r_wePrev && !r_weSync[1];
  assign w_oeFall = r_oePrev && !r_oeSync[1];
  assign w_oeRise = !r_oePrev && r_oeSync[1];

  assign w_addrCmd    = (mc_add == MC_ADD_WIDTH'(ADDR_CMD));
  assign w_addrStatus = (mc_add == MC_ADD_WIDTH'(ADDR_STATUS));
  assign w_addrCtrl   = (mc_add == MC_ADD_WIDTH'(ADDR_CTRL));

  assign w_cmdWrite  = w_weFall && w_addrCmd;
  assign w_ctrlWrite = w_weFall && w_addrCtrl;
  assign w_flush     = w_ctrlWrite && mc_din[CTRL_FLUSH_BIT];
  assign w_clear     = w_ctrlWrite && mc_din[CTRL_CLEAR_BIT];
  assign w_resPop    = w_oeRise && r_popPending;
  assign w_busy      = (r_state != ST_IDLE);

  assign w_status = {5'(w_cmdCount), 5'(w_resCount), w_busy, r_run,
                     r_timeout, r_underflow, r_overflow, !w_resEmpty};

  assign mc_dout    = r_dout;
  assign mc_dout_en = !r_oeSync[1];
  assign eng_cmd    = r_engCmd;
  assign eng_data   = r_engData;
  assign irq0       = !w_resEmpty;
  assign irq1       = r_timeout || r_underflow || r_overflow;

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_cmdFifo (
    .clock(clock), .reset(reset), .i_push(w_cmdWrite), .i_pop(w_cmdPop),
    .i_flush(w_flush), .i_din(16'(mc_din)), .o_dout(w_cmdHead),
    .o_full(w_cmdFull), .o_empty(w_cmdEmpty), .o_count(w_cmdCount)
  );

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_resFifo (
    .clock(clock), .reset(reset), .i_push(w_resPush), .i_pop(w_resPop),
    .i_flush(w_flush), .i_din({r_engCmd, r_engRdata}), .o_dout(w_resHead),
    .o_full(w_resFull), .o_empty(w_resEmpty), .o_count(w_resCount)
  );

  // Double-flop the MCU strobes and keep one more stage for edge detection;
  // everything resets to the inactive (high) level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_weSync <= 2'b11;
      r_oeSync <= 2'b11;
      r_wePrev <= 1'b1;
      r_oePrev <= 1'b1;
    end else begin
      r_weSync <= {r_weSync[0], mc_we};
      r_oeSync <= {r_oeSync[0], mc_oe};
      r_wePrev <= r_weSync[1];
      r_oePrev <= r_oeSync[1];
    end
  end

  // Read data is captured at read-start; the result FIFO pop is deferred
  // until read-end so the MCU sees a stable head for the whole access.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dout       <= '0;
      r_popPending <= 1'b0;
    end else if (w_oeFall) begin
      r_popPending <= 1'b0;
      if (w_addrCmd) begin
        r_dout       <= w_resEmpty ? '0 : MC_DATA_WIDTH'(w_resHead);
        r_popPending <= !w_resEmpty;
      end else if (w_addrStatus) begin
        r_dout <= MC_DATA_WIDTH'(w_status);
      end else begin
        r_dout <= '0;
      end
    end else if (w_oeRise || w_flush) begin
      r_popPending <= 1'b0;
    end
  end

  // Run bit and sticky error flags; a clear request wins over new errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_run       <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_ctrlWrite) r_run <= mc_din[CTRL_RUN_BIT];
      if (w_clear) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
        r_timeout   <= 1'b0;
      end else begin
        if (w_cmdWrite && w_cmdFull && !w_cmdPop)  r_overflow  <= 1'b1;
        if (w_oeFall && w_addrCmd && w_resEmpty)   r_underflow <= 1'b1;
        if (w_setTimeout)                          r_timeout   <= 1'b1;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state and strobe decode. A flush seen while a command is in flight
  // (tracked in r_discard) or in the same cycle as eng_done drops its result.
  always_comb begin
    w_nextState  = r_state;
    w_cmdPop     = 1'b0;
    w_resPush    = 1'b0;
    w_setTimeout = 1'b0;
    eng_start    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_run && !w_cmdEmpty) w_nextState = ST_ISSUE;
      end
      ST_ISSUE: begin
        eng_start   = 1'b1;
        w_cmdPop    = 1'b1;
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          w_nextState = (r_engCmd[7] && !r_discard && !w_flush) ? ST_STORE : ST_IDLE;
        end else if (r_waitCnt == TW'(TIMEOUT - 1)) begin
          w_setTimeout = 1'b1;
          w_nextState  = ST_IDLE;
        end
      end
      ST_STORE: begin
        if (w_flush) begin
          w_nextState = ST_IDLE;
        end else if (!w_resFull || w_resPop) begin
          w_resPush   = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Transaction datapath: command latched as the FSM leaves IDLE so it is
  // valid during the issue strobe, wait counter, captured result, discard.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_engCmd   <= '0;
      r_engData  <= '0;
      r_engRdata <= '0;
      r_waitCnt  <= '0;
      r_discard  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_nextState == ST_ISSUE) begin
        r_engCmd  <= w_cmdHead[15:8];
        r_engData <= w_cmdHead[7:0];
      end
      if (r_state == ST_ISSUE)     r_waitCnt <= '0;
      else if (r_state == ST_WAIT) r_waitCnt <= r_waitCnt + 1'b1;
      if (r_state == ST_WAIT && eng_done) r_engRdata <= eng_rdata;
      if (r_state == ST_IDLE) r_discard <= 1'b0;
      else if (w_flush)       r_discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_cmd_sequencer
// Directed bench: an MCU bus driver, a simple engine responder and a table of
// command transactions with hand-computed results, plus corner sequences.
// ---------------------------------------------------------------------------
module tb_mc_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        mc_we, mc_oe;
  logic [5:0]  mc_add;
  logic [15:0] mc_din;
  logic [15:0] mc_dout;
  logic        mc_dout_en;
  logic        eng_start;
  logic [7:0]  eng_cmd, eng_data;
  logic        eng_done;
  logic [7:0]  eng_rdata;
  logic        irq0, irq1;

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;
  int startCount = 0;
  int startCycle = 0;
  logic [7:0] lastCmd, lastData;

  logic       engRespond  = 1'b1;
  logic       engUseTable = 1'b1;
  int         engDelay    = 5;
  logic [7:0] engResult   = 8'h00;

  typedef struct {
    logic [15:0] cmdWord;
    logic [7:0]  engRes;
    logic [7:0]  expCmd;
    logic [7:0]  expData;
    logic        expIrq0;
    logic [15:0] expRead;
  } vec_t;

  vec_t vecs[5];

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  mc_cmd_sequencer #(
    .MC_ADD_WIDTH(6), .MC_DATA_WIDTH(16), .FIFO_DEPTH(16), .TIMEOUT(1024)
  ) dut (
    .clock(clock), .reset(reset), .mc_we(mc_we), .mc_oe(mc_oe),
    .mc_add(mc_add), .mc_din(mc_din), .mc_dout(mc_dout),
    .mc_dout_en(mc_dout_en), .eng_start(eng_start), .eng_cmd(eng_cmd),
    .eng_data(eng_data), .eng_done(eng_done), .eng_rdata(eng_rdata),
    .irq0(irq0), .irq1(irq1)
  );

  // Records every cycle eng_start is seen high, with the opcode/operand.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (eng_start) begin
        startCount = startCount + 1;
        lastCmd    = eng_cmd;
        lastData   = eng_data;
        startCycle = cycleCnt;
      end
    end
  end

  // Engine model: answers each start after engDelay cycles with a one-cycle
  // done pulse; result from the table or operand + 0x10.
  initial begin
    logic [7:0] rd;
    eng_done  = 1'b0;
    eng_rdata = 8'h00;
    forever begin
      @(posedge clock); #1;
      if (eng_start && engRespond) begin
        rd = engUseTable ? engResult : eng_data + 8'h10;
        repeat (engDelay) @(posedge clock);
        #1;
        eng_done  = 1'b1;
        eng_rdata = rd;
        @(posedge clock); #1;
        eng_done  = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared = compared + 1;
    if (actual !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic mcuWrite(input logic [5:0] addr, input logic [15:0] data);
    mc_add = addr;
    mc_din = data;
    mc_we  = 1'b0;
    cycles(3);
    mc_we  = 1'b1;
    cycles(4);
  endtask

  task automatic mcuRead(input logic [5:0] addr, output logic [15:0] data,
                         output logic en);
    mc_add = addr;
    mc_oe  = 1'b0;
    cycles(4);
    data   = mc_dout;
    en     = mc_dout_en;
    mc_oe  = 1'b1;
    cycles(4);
  endtask

  task automatic readStatus(output logic [15:0] s);
    logic en;
    mcuRead(6'h01, s, en);
  endtask

  // One queued command: check the issued opcode/operand and the result path.
  task automatic applyStimulus(input vec_t v, input int idx);
    int base;
    logic [15:0] rd;
    logic en;
    engResult = v.engRes;
    base = startCount;
    mcuWrite(6'h00, v.cmdWord);
    cycles(25);
    checkOutput($sformatf("vec%0d starts", idx), 16'(startCount - base), 16'd1);
    checkOutput($sformatf("vec%0d eng_cmd", idx), {8'h00, lastCmd}, {8'h00, v.expCmd});
    checkOutput($sformatf("vec%0d eng_data", idx), {8'h00, lastData}, {8'h00, v.expData});
    checkOutput($sformatf("vec%0d irq0", idx), {15'd0, irq0}, {15'd0, v.expIrq0});
    if (v.expIrq0) begin
      mcuRead(6'h00, rd, en);
      checkOutput($sformatf("vec%0d result", idx), rd, v.expRead);
      checkOutput($sformatf("vec%0d irq0 after read", idx), {15'd0, irq0}, 16'd0);
    end
  endtask

  initial begin
    logic [15:0] s;
    logic [15:0] rd;
    logic en;
    int base;

    vecs[0] = '{16'h0055, 8'h11, 8'h00, 8'h55, 1'b0, 16'h0000};
    vecs[1] = '{16'h8020, 8'hA5, 8'h80, 8'h20, 1'b1, 16'h80A5};
    vecs[2] = '{16'h7F01, 8'h3C, 8'h7F, 8'h01, 1'b0, 16'h0000};
    vecs[3] = '{16'hC3FF, 8'h00, 8'hC3, 8'hFF, 1'b1, 16'hC300};
    vecs[4] = '{16'h8000, 8'hFF, 8'h80, 8'h00, 1'b1, 16'h80FF};

    reset  = 1'b1;
    mc_we  = 1'b1;
    mc_oe  = 1'b1;
    mc_add = 6'h00;
    mc_din = 16'h0000;
    cycles(3);
    reset = 1'b0;
    cycles(1);

    $display("[TB] reset state");
    checkOutput("rst eng_start", {15'd0, eng_start}, 16'd0);
    checkOutput("rst eng_cmd", {eng_cmd, eng_data}, 16'h0000);
    checkOutput("rst irqs", {14'd0, irq1, irq0}, 16'd0);
    checkOutput("rst dout_en", {15'd0, mc_dout_en}, 16'd0);
    checkOutput("rst dout", mc_dout, 16'h0000);
    mcuRead(6'h01, s, en);
    checkOutput("rst status", s, 16'h0000);
    checkOutput("dout_en during read", {15'd0, en}, 16'd1);
    mcuRead(6'h05, s, en);
    checkOutput("unmapped read", s, 16'h0000);

    $display("[TB] underflow and clear");
    mcuRead(6'h00, rd, en);
    checkOutput("empty result read", rd, 16'h0000);
    readStatus(s);
    checkOutput("underflow status", s, 16'h0004);
    checkOutput("underflow irq1", {15'd0, irq1}, 16'd1);
    mcuWrite(6'h02, 16'h0004);
    readStatus(s);
    checkOutput("cleared status", s, 16'h0000);
    checkOutput("cleared irq1", {15'd0, irq1}, 16'd0);

    $display("[TB] command overflow");
    mcuWrite(6'h02, 16'h0000);
    for (int i = 0; i < 17; i++) mcuWrite(6'h00, 16'h0100 + 16'(i));
    readStatus(s);
    checkOutput("overflow status", s, 16'h8002);
    checkOutput("overflow irq1", {15'd0, irq1}, 16'd1);
    mcuWrite(6'h02, 16'h0006);
    readStatus(s);
    checkOutput("flush+clear status", s, 16'h0000);

    $display("[TB] command table");
    engUseTable = 1'b1;
    engDelay    = 5;
    mcuWrite(6'h02, 16'h0003);
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    $display("[TB] flush while waiting");
    engDelay = 20;
    base = startCount;
    mcuWrite(6'h00, 16'h8077);
    mcuWrite(6'h02, 16'h0003);
    cycles(40);
    checkOutput("flush starts", 16'(startCount - base), 16'd1);
    checkOutput("flush irq0", {15'd0, irq0}, 16'd0);
    readStatus(s);
    checkOutput("flush status", s, 16'h0010);

    $display("[TB] engine timeout");
    engRespond = 1'b0;
    mcuWrite(6'h00, 16'h0011);
    for (int i = 0; i < 1200; i++) begin
      if (irq1) break;
      cycles(1);
    end
    checkOutput("timeout latency", 16'(cycleCnt - startCycle), 16'd1025);
    readStatus(s);
    checkOutput("timeout status", s, 16'h0018);
    mcuWrite(6'h02, 16'h0005);
    readStatus(s);
    checkOutput("timeout cleared", s, 16'h0010);
    engRespond = 1'b1;

    $display("[TB] result FIFO full");
    engUseTable = 1'b0;
    engDelay    = 5;
    for (int i = 0; i < 17; i++) mcuWrite(6'h00, 16'h8000 | 16'(i));
    cycles(100);
    readStatus(s);
    checkOutput("store hold status", s, 16'h0431);
    mcuRead(6'h00, rd, en);
    checkOutput("full first entry", rd, 16'h8010);
    readStatus(s);
    checkOutput("after release status", s, 16'h0411);
    for (int i = 1; i <= 16; i++) begin
      mcuRead(6'h00, rd, en);
      checkOutput($sformatf("drain %0d", i), rd, 16'h8000 | (16'h0010 + 16'(i)));
    end
    checkOutput("drained irq0", {15'd0, irq0}, 16'd0);

    $display("[TB] reset mid-wait");
    engDelay = 20;
    mcuWrite(6'h00, 16'h8099);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(30);
    checkOutput("post-reset irqs", {14'd0, irq1, irq0}, 16'd0);
    readStatus(s);
    checkOutput("post-reset status", s, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_cmd_sequencer.md
MC_CMD_SEQUENCER -- requirements
Module: mc_cmd_sequencer

Interface
REQ-001 SHALL have parameter MC_ADD_WIDTH, default 6, MCU address width.
REQ-002 SHALL have parameter MC_DATA_WIDTH, default 16, MCU data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entries per FIFO (power of two).
REQ-004 SHALL have parameter TIMEOUT, default 1024, max clock cycles waiting for eng_done.
REQ-005 SHALL have ports:
clock  in  1  system clock; one clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
mc_we  in  1  MCU write strobe, active low, asynchronous to clock.
mc_oe  in  1  MCU read strobe, active low, asynchronous to clock.
mc_add  in  MC_ADD_WIDTH  MCU register address.
mc_din  in  MC_DATA_WIDTH  MCU write data.
mc_dout  out  MC_DATA_WIDTH  registered read data.
mc_dout_en  out  1  high while the block drives mc_data.
eng_start  out  1  one-cycle command strobe to the protocol engine.
eng_cmd  out  8  opcode for the engine.
eng_data  out  8  operand for the engine.
eng_done  in  1  one-cycle completion pulse from the engine.
eng_rdata  in  8  engine result, valid with eng_done.
irq0  out  1  result FIFO not empty.
irq1  out  1  any error flag set.

Function
REQ-006 SHALL double-flop mc_we and mc_oe; strobe events are edges of the synchronized signals, and mc_add/mc_din are sampled on the same cycle as the event.
REQ-007 Write event = synchronized mc_we falling edge; read-start = synchronized mc_oe falling edge; read-end = its rising edge.
REQ-008 Write to 0x00 SHALL push mc_din into the command FIFO ({opcode[15:8], operand[7:0]}); if full, drop the word and set overflow.
REQ-009 Write to 0x02 SHALL set: bit0 run (level), bit1 flush both FIFOs (self-clearing), bit2 clear all error flags (self-clearing).
REQ-010 Read of 0x00 SHALL present the result FIFO head on mc_dout one cycle after read-start and pop it at read-end; if empty, present 0x0000, no pop, set underflow.
REQ-011 Read of 0x01 SHALL return status {cmd_count[4:0], res_count[4:0], busy, run, timeout, underflow, overflow, res_not_empty} (bits 15..0).
REQ-012 Reads of other addresses SHALL return 0x0000; writes to other addresses SHALL be ignored.
REQ-013 mc_dout_en SHALL equal the inverted synchronized mc_oe.
REQ-014 FSM states IDLE, ISSUE, WAIT, STORE.
REQ-015 IDLE -> ISSUE when run=1 and command FIFO not empty.
REQ-016 ISSUE: eng_start=1 for exactly one cycle with eng_cmd/eng_data from FIFO head, pop the FIFO, -> WAIT.
REQ-017 WAIT: on eng_done -> STORE if opcode bit7=1, else IDLE; if the wait counter reaches TIMEOUT -> set timeout, -> IDLE.
REQ-018 STORE: push {opcode, eng_rdata} into the result FIFO and -> IDLE; if full, hold in STORE without loss until space.
REQ-019 Simultaneous MCU push and sequencer pop on one FIFO SHALL both take effect, count unchanged.
REQ-020 Flush SHALL empty both FIFOs in one cycle; an in-flight WAIT completes, but its STORE result is discarded if the flush preceded eng_done.
REQ-021 Clearing run mid-transaction SHALL complete the current command and issue no further ones.
REQ-022 busy SHALL be 1 whenever the state is not IDLE; eng_done outside WAIT SHALL be ignored.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; counts SHALL range 0..FIFO_DEPTH.

Reset
REQ-024 Reset SHALL force IDLE, empty FIFOs, run=0, all flags 0, mc_dout=0, mc_dout_en=0, eng_start=0, eng_cmd=0, eng_data=0, irq0=0, irq1=0, and synchronizer flops to 1 (inactive).
REQ-025 Reset mid-WAIT SHALL abandon the transaction; an eng_done arriving after reset SHALL be ignored.

Structure
REQ-026 Address constants (0x00, 0x01, 0x02), control bit indices and the FSM state enum SHALL live in shared package bp_pkg.
REQ-027 The two FIFOs SHALL be instances of one sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count/flush).

Verification
REQ-028 Write 0x0003 to 0x02, then 0x0055 to 0x00; engine done after 5 cycles -> one eng_start with cmd 0x00, data 0x55; result FIFO stays empty.
REQ-029 With run=1, write 0x8020 to 0x00, engine returns 0xA5 -> irq0=1; read 0x00 returns 0x80A5; irq0=0 after read-end.
REQ-030 With run=0, write 17 commands -> status reads cmd_count=16 and overflow=1; irq1=1.
REQ-031 With run=1 and engine never asserting eng_done -> timeout=1 after exactly TIMEOUT cycles in WAIT; FSM returns to IDLE.
REQ-032 Fill result FIFO (16 entries), issue one more capture command -> FSM holds in STORE; one MCU read -> entry stored, res_count=16.
REQ-033 Read 0x00 with the result FIFO empty -> 0x0000 returned, underflow=1; write 0x0004 to 0x02 -> all flags 0.
